// File: rtl/snake_pkg.sv
// Shared definitions for the snake game blocks.
// Holds the direction encoding used by the input stage, the controller
// and the datapath, plus a helper that detects a 180-degree turn.
package snake_pkg;

  typedef enum logic [1:0] {
    LEFT  = 2'b00,
    UP    = 2'b01,
    DOWN  = 2'b10,
    RIGHT = 2'b11
  } dir_t;

  // Opposite directions differ in both bits with this encoding.
  function automatic logic is_reversal(input logic [1:0] a, input logic [1:0] b);
    return (a ^ b) == 2'b11;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Synchronises and debounces one raw active-low push button.
// Ports:
//   clk     - system clock
//   resetn  - synchronous active-low reset
//   raw_n   - raw asynchronous button level, low = pressed
//   level   - debounced button level, low = pressed
//   press   - one-cycle pulse when the debounced level falls 1->0
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic resetn,
  input  logic raw_n,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchroniser, then a stability counter that must see the
  // new level for DEBOUNCE_CYCLES consecutive cycles before accepting it.
  // The press pulse is raised in the same cycle the level drops to 0.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= raw_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
        press <= ~sync2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/turn_queue.sv
// Input stage for the snake controller: debounces the four KEY buttons,
// validates each press as a turn and buffers valid turns in a FIFO that
// is popped once per game step.
// Ports:
//   clk       - 50 MHz system clock
//   resetn    - synchronous active-low reset
//   key_n     - raw KEYs, active-low: [0] right, [1] up, [2] down, [3] left
//   tick      - one-cycle pulse per game step, pops one queued turn
//   direction - direction for the current step (LEFT=00 UP=01 DOWN=10 RIGHT=11)
//   pending   - number of queued turns
//   dropped   - pulse: press rejected as duplicate or reversal
//   overflow  - pulse: valid press lost because the FIFO was full
module turn_queue
  import snake_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = 250000,
  parameter int         DEPTH           = 4,
  parameter logic [1:0] INIT_DIR        = 2'b11
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [3:0]                 key_n,
  input  logic                       tick,
  output logic [1:0]                 direction,
  output logic [$clog2(DEPTH):0]     pending,
  output logic                       dropped,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [3:0]       key_level;
  logic [3:0]       key_press;
  logic [3:0]       key_hit;

  logic [1:0]       fifo [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic             cand_valid;
  logic [1:0]       cand_dir;
  logic [1:0]       ref_dir;
  logic             full;
  logic             accept;
  logic             do_push;
  logic             do_pop;

  for (genvar k = 0; k < 4; k++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .resetn (resetn),
      .raw_n  (key_n[k]),
      .level  (key_level[k]),
      .press  (key_press[k])
    );
  end

  // A press only counts while the debounced key is actually held.
  assign key_hit = key_press & ~key_level;

  // Pick at most one candidate per cycle: right > down > up > left.
  always_comb begin
    cand_valid = 1'b0;
    cand_dir   = RIGHT;
    if (key_hit[0]) begin
      cand_valid = 1'b1;
      cand_dir   = RIGHT;
    end else if (key_hit[2]) begin
      cand_valid = 1'b1;
      cand_dir   = DOWN;
    end else if (key_hit[1]) begin
      cand_valid = 1'b1;
      cand_dir   = UP;
    end else if (key_hit[3]) begin
      cand_valid = 1'b1;
      cand_dir   = LEFT;
    end
  end

  // A new turn is judged against the last turn that will be applied:
  // the newest queued entry, or the current direction if nothing is queued.
  // This uses the state before any pop in the same cycle.
  always_comb begin
    ref_dir = direction;
    if (pending != '0) begin
      ref_dir = fifo[wr_ptr - PTR_W'(1)];
    end
    full    = (pending == CNT_W'(DEPTH));
    accept  = cand_valid && (cand_dir != ref_dir) && !is_reversal(cand_dir, ref_dir);
    do_pop  = tick && (pending != '0);
    // A full queue still accepts when a pop frees a slot this cycle.
    do_push = accept && (!full || tick);
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) begin
      fifo[wr_ptr] <= cand_dir;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pending   <= '0;
      direction <= INIT_DIR;
      dropped   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        direction <= fifo[rd_ptr];
        rd_ptr    <= rd_ptr + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        pending <= pending + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        pending <= pending - CNT_W'(1);
      end
      dropped  <= cand_valid && !accept;
      overflow <= accept && full && !tick;
    end
  end

endmodule

// File: tb/tb_turn_queue.sv
// Self-checking bench for turn_queue with a queue-based reference model.
module tb_turn_queue;

  localparam int DEB   = 4;
  localparam int DEPTH = 4;
  localparam int PW    = $clog2(DEPTH) + 1;
  // Clock edges from driving a key low to the edge that enqueues it:
  // 2 sync + DEB + 1.
  localparam int ENQ_EDGE = 2 + DEB + 1;

  logic          clk    = 1'b0;
  logic          resetn = 1'b0;
  logic [3:0]    key_n  = 4'hF;
  logic          tick   = 1'b0;
  logic [1:0]    direction;
  logic [PW-1:0] pending;
  logic          dropped;
  logic          overflow;

  turn_queue #(
    .DEBOUNCE_CYCLES (DEB),
    .DEPTH           (DEPTH),
    .INIT_DIR        (2'b11)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .key_n     (key_n),
    .tick      (tick),
    .direction (direction),
    .pending   (pending),
    .dropped   (dropped),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Pulse counters, sampled on the falling edge away from DUT updates.
  int drop_seen = 0;
  int ovf_seen  = 0;
  always @(negedge clk) begin
    if (dropped)  drop_seen++;
    if (overflow) ovf_seen++;
  end

  // Reference model state.
  logic [1:0] mq[$];
  logic [1:0] mdir    = 2'b11;
  int         exp_drop = 0;
  int         exp_ovf  = 0;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".direction"}, 8'(direction), 8'(mdir));
    checkVal({tag, ".pending"},   8'(pending),   8'(mq.size()));
    checkVal({tag, ".dropped"},   8'(drop_seen), 8'(exp_drop));
    checkVal({tag, ".overflow"},  8'(ovf_seen),  8'(exp_ovf));
  endtask

  function automatic logic [1:0] keyDir(input int k);
    case (k)
      0:       return 2'b11;
      1:       return 2'b01;
      2:       return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Model of one press event (mask of keys whose events coincide),
  // optionally in the same cycle as a tick.
  task automatic modelPress(input logic [3:0] mask, input bit with_tick);
    int         order[4] = '{0, 2, 1, 3};
    int         k = -1;
    logic [1:0] cand;
    logic [1:0] rdir;
    bit         ok;
    foreach (order[i]) if (k < 0 && mask[order[i]]) k = order[i];
    if (k >= 0) begin
      cand = keyDir(k);
      rdir = (mq.size() > 0) ? mq[$] : mdir;
      ok   = (cand != rdir) && ((cand ^ rdir) != 2'b11);
    end else begin
      cand = 2'b00;
      ok   = 1'b0;
    end
    if (with_tick && mq.size() > 0) mdir = mq.pop_front();
    if (k >= 0) begin
      if (!ok)                     exp_drop++;
      else if (mq.size() < DEPTH)  mq.push_back(cand);
      else                         exp_ovf++;
    end
  endtask

  // Press the keys in mask together, hold, release and let things settle.
  task automatic applyStimulus(input logic [3:0] mask);
    key_n = ~mask;
    step(12);
    key_n = 4'hF;
    step(10);
    modelPress(mask, 1'b0);
  endtask

  // Same, but tick lands on the enqueue edge of the press event.
  task automatic applyStimulusWithTick(input logic [3:0] mask);
    key_n = ~mask;
    step(ENQ_EDGE - 1);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(5);
    key_n = 4'hF;
    step(10);
    modelPress(mask, 1'b1);
  endtask

  task automatic doTick();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(1);
    if (mq.size() > 0) mdir = mq.pop_front();
  endtask

  task automatic doReset(input int n);
    resetn = 1'b0;
    step(n);
    resetn = 1'b1;
    step(1);
    mq.delete();
    mdir = 2'b11;
  endtask

  initial begin
    int act;
    logic [3:0] m;

    // 1. Reset
    doReset(3);
    checkOutput("reset");
    doTick();
    checkOutput("reset_tick");

    // 2. Bounce rejection on UP, then a clean hold
    for (int i = 0; i < 5; i++) begin
      key_n[1] = 1'b0; step(2);
      key_n[1] = 1'b1; step(2);
    end
    checkOutput("bounce_none");
    key_n[1] = 1'b0;
    step(10);
    key_n[1] = 1'b1;
    step(10);
    modelPress(4'b0010, 1'b0);
    checkOutput("bounce_one");
    doTick();
    checkOutput("bounce_tick");

    // 3. Double tap
    doReset(1);
    applyStimulus(4'b0010);
    applyStimulus(4'b1000);
    checkOutput("dtap_queued");
    doTick();
    checkOutput("dtap_tick1");
    doTick();
    checkOutput("dtap_tick2");
    doTick();
    checkOutput("dtap_tick3");

    // 4. Reversal and duplicate
    doReset(1);
    applyStimulus(4'b1000);
    checkOutput("rev_left");
    applyStimulus(4'b0001);
    checkOutput("dup_right");
    applyStimulus(4'b0010);
    checkOutput("ok_up");
    applyStimulus(4'b0100);
    checkOutput("rev_down");

    // 5. Overflow and full push-pop
    doReset(1);
    applyStimulus(4'b0010);
    applyStimulus(4'b1000);
    applyStimulus(4'b0100);
    applyStimulus(4'b0001);
    checkOutput("full");
    applyStimulus(4'b0010);
    checkOutput("overflow");
    applyStimulusWithTick(4'b0010);
    checkOutput("full_pushpop");

    // 6. Priority and reset mid-queue
    doReset(1);
    applyStimulus(4'b1001);
    checkOutput("priority");
    applyStimulus(4'b0010);
    checkOutput("pre_reset");
    doReset(1);
    checkOutput("mid_reset");

    // Random mix of presses, ticks, coincident press+tick and resets
    for (int i = 0; i < 60; i++) begin
      act = $urandom_range(0, 9);
      m   = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 2) != 0) m = 4'(1 << $urandom_range(0, 3));
      if (act < 5)       applyStimulus(m);
      else if (act < 8)  doTick();
      else if (act < 9)  applyStimulusWithTick(m);
      else               doReset($urandom_range(1, 3));
      checkOutput("random");
    end

    $display("[TB] random phase complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guard against a hang.
  initial begin
    #500000;
    $display("[TB] FAIL timeout: observed running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
